axil_cmd_master: RTL

- Generic AXI4-Lite initiator. Converts a simple single-beat command/response port into AXI4-Lite read and write transactions.
- Lets internal sequencers and test logic drive any AXI4-Lite slave in the design, including the offset-remapped memory slaves.
- Handles one outstanding transaction at a time.
- A per-instance base offset is added to every command address.

---
 rtl/axil_cmd_master_if.sv | 39 +++
 rtl/axil_cmd_master.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/axil_cmd_master_if.sv
// ---------------------------------------------------------------------------
// axi4_lite_if
//   AXI4-Lite bundle with a 32-bit address and 32-bit data.
//   Modport m : initiator side (drives aw*, w*, ar*, bready, rready).
//   Modport s : target side    (drives awready, wready, b*, arready, r*).
// ---------------------------------------------------------------------------
interface axi4_lite_if;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport m (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport s (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_cmd_master.sv
// ---------------------------------------------------------------------------
// axil_cmd_master
//   Generic AXI4-Lite initiator. Turns a single-beat command/response port
//   into one AXI4-Lite read or write at a time. A per-instance base offset
//   is added (mod 2^32) to every command address at accept.
//
// Optional feature (macro AXIL_CMD_TIMEOUT_EN): a watchdog aborts any
//   transaction still running TIMEOUT_CYCLES cycles after accept and
//   returns rsp_resp = 2'b10 with rsp_timeout = 1. Without the macro the
//   block waits indefinitely and rsp_timeout_o is tied to 0.
//
// Ports:
//   aclk_i        clock, everything on the rising edge
//   aresetn_i     synchronous active-low reset
//   axi           AXI4-Lite initiator (axi4_lite_if.m)
//   offset_i      base added to req_addr_i, sampled at accept
//   req_valid_i   command present
//   req_ready_o   block idle; accept = req_valid_i & req_ready_o
//   req_we_i      1 = write, 0 = read
//   req_addr_i    byte address before offset
//   req_wdata_i   write data
//   req_wstrb_i   write byte strobes
//   rsp_valid_o   one-cycle response pulse
//   rsp_rdata_o   read data (0 for writes and timeouts)
//   rsp_resp_o    BRESP/RRESP, or 2'b10 on timeout
//   rsp_timeout_o transaction aborted by the watchdog
// ---------------------------------------------------------------------------
module axil_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        aclk_i,
    input  logic        aresetn_i,
    axi4_lite_if.m      axi,
    input  logic [31:0] offset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_wstrb_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic [1:0]  rsp_resp_o,
    output logic        rsp_timeout_o
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("axil_cmd_master: TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [2:0] {IDLE, WRITE, WR_RESP, READ, RD_DATA, RESP} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  resp_q, resp_d;
    logic        accept;
    logic        aw_fire;
    logic        w_fire;

    // Outside IDLE every handshake signal is a pure function of the state;
    // the done flags let aw and w complete independently in WRITE.
    assign req_ready_o  = (state_q == IDLE) & aresetn_i;
    assign accept       = req_valid_i & req_ready_o;
    assign axi.awaddr   = addr_q;
    assign axi.araddr   = addr_q;
    assign axi.awprot   = 3'b000;
    assign axi.arprot   = 3'b000;
    assign axi.wdata    = wdata_q;
    assign axi.wstrb    = wstrb_q;
    assign axi.awvalid  = (state_q == WRITE) & ~aw_done_q;
    assign axi.wvalid   = (state_q == WRITE) & ~w_done_q;
    assign axi.bready   = (state_q == WR_RESP);
    assign axi.arvalid  = (state_q == READ);
    assign axi.rready   = (state_q == RD_DATA);
    assign rsp_valid_o  = (state_q == RESP);
    assign rsp_rdata_o  = rdata_q;
    assign rsp_resp_o   = resp_q;
    assign aw_fire      = axi.awvalid & axi.awready;
    assign w_fire       = axi.wvalid & axi.wready;

`ifdef AXIL_CMD_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // Abort is decided in cycle TIMEOUT_CYCLES-1 after accept (count value
    // TIMEOUT_CYCLES-2), so the response lands TIMEOUT_CYCLES cycles after.
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 2);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             busy;
    logic             hs_fire;
    logic             expire;

    assign busy    = state_q inside {WRITE, WR_RESP, READ, RD_DATA};
    // A handshake landing on the expiry cycle wins over the abort.
    assign hs_fire = aw_fire | w_fire | (axi.bvalid & axi.bready)
                   | (axi.arvalid & axi.arready) | (axi.rvalid & axi.rready);
    assign expire  = busy & ~hs_fire & (cnt_q >= LIMIT);
    assign rsp_timeout_o = timeout_q;
`else
    assign rsp_timeout_o = 1'b0;
`endif

    // Next-state logic: captures the command at accept, tracks the two
    // write channels separately, and captures the slave response.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
`ifdef AXIL_CMD_TIMEOUT_EN
        timeout_d = timeout_q;
        cnt_d     = (busy && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d    = req_addr_i + offset_i;
                    wdata_d   = req_wdata_i;
                    wstrb_d   = req_wstrb_i;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = req_we_i ? WRITE : READ;
`ifdef AXIL_CMD_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end
            end
            WRITE: begin
                aw_done_d = aw_done_q | aw_fire;
                w_done_d  = w_done_q | w_fire;
                if ((aw_done_q | aw_fire) & (w_done_q | w_fire)) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (axi.bvalid) begin
                    rdata_d = '0;
                    resp_d  = axi.bresp;
                    state_d = RESP;
`ifdef AXIL_CMD_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                end
            end
            READ: begin
                if (axi.arready) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (axi.rvalid) begin
                    rdata_d = axi.rdata;
                    resp_d  = axi.rresp;
                    state_d = RESP;
`ifdef AXIL_CMD_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
`ifdef AXIL_CMD_TIMEOUT_EN
        if (expire) begin
            state_d   = RESP;
            rdata_d   = '0;
            resp_d    = 2'b10;
            timeout_d = 1'b1;
        end
`endif
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge aclk_i) begin
        if (!aresetn_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
        end
    end

`ifdef AXIL_CMD_TIMEOUT_EN
    // Watchdog counter and the held timeout flag.
    always_ff @(posedge aclk_i) begin
        if (!aresetn_i) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
`endif

endmodule
